// File: rtl/branch_pkg.sv
// Shared definitions for the branch condition unit: funct3 encodings,
// counter width and the registered decision record.
package branch_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    F_BEQ  = 3'b000,
    F_BNE  = 3'b001,
    F_BLT  = 3'b100,
    F_BGE  = 3'b101,
    F_BLTU = 3'b110,
    F_BGEU = 3'b111
  } funct3_e;

  typedef struct packed {
    logic taken;
    logic illegal;
  } decision_t;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Handshake bundle between the add/sub stage, the branch condition unit
// and the decision consumer.
interface branch_cond_unit_if;
  import branch_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic             sub;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             illegal;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output in_valid, funct3, sub, N, Z, C, V, out_ready,
    input  in_ready, out_valid, taken, illegal, taken_cnt
  );

  modport slave (
    input  in_valid, funct3, sub, N, Z, C, V, out_ready,
    output in_ready, out_valid, taken, illegal, taken_cnt
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from the a-b adder flags.
// C=1 means no borrow, so unsigned a>=b is simply C.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       sub,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  output logic       taken,
  output logic       illegal
);

  logic cond;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F_BEQ:   cond = Z;
      F_BNE:   cond = !Z;
      F_BLT:   cond = N ^ V;
      F_BGE:   cond = !(N ^ V);
      F_BLTU:  cond = !C;
      F_BGEU:  cond = C;
      default: illegal = 1'b1;
    endcase
    // A decision is only meaningful when the adder actually subtracted.
    if (!sub) illegal = 1'b1;
    taken = cond && !illegal;
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: one-deep registered decision with valid/ready
// handshake. Define BRANCH_STATS_EN to build the saturating taken counter.
module branch_cond_unit
  import branch_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  branch_cond_unit_if.slave  bus
);

  logic      eval_taken;
  logic      eval_illegal;
  logic      valid_q;
  decision_t dec_q;
  logic      accept;
  logic      deliver;

  branch_cond_eval u_eval (
    .funct3  (bus.funct3),
    .sub     (bus.sub),
    .N       (bus.N),
    .Z       (bus.Z),
    .C       (bus.C),
    .V       (bus.V),
    .taken   (eval_taken),
    .illegal (eval_illegal)
  );

  assign bus.in_ready = !rstn && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rstn) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= '{taken: eval_taken, illegal: eval_illegal};
    end else if (deliver) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.taken     = dec_q.taken;
  assign bus.illegal   = dec_q.illegal;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q <= '0;
    end else if (deliver && dec_q.taken && !dec_q.illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.taken_cnt = cnt_q;
`else
  assign bus.taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed corner cases plus random traffic,
// checked every cycle against an operand-level reference model.
module tb_branch_cond_unit;
  import branch_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  branch_cond_unit_if bus ();

  branch_cond_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decision straight from the operand values.
  function automatic void ref_decide(input logic [2:0] f, input logic s,
                                     input logic [7:0] a, input logic [7:0] b,
                                     output logic t, output logic il);
    logic r;
    il = !s || (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = ($signed(a) <  $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a <  b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    t = il ? 1'b0 : r;
  endfunction

  logic [7:0] cur_a = '0;
  logic [7:0] cur_b = '0;

  task automatic drive(input logic v, input logic [2:0] f, input logic s,
                       input logic [7:0] a, input logic [7:0] b, input logic ordy);
    logic [8:0] sum;
    sum   = {1'b0, a} + {1'b0, ~b} + 9'd1;
    cur_a = a;
    cur_b = b;
    bus.in_valid  = v;
    bus.funct3    = f;
    bus.sub       = s;
    bus.N         = sum[7];
    bus.Z         = (sum[7:0] == 8'h00);
    bus.C         = sum[8];
    bus.V         = (a[7] != b[7]) && (sum[7] != a[7]);
    bus.out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue holding at most one pending decision.
  typedef struct {
    logic t;
    logic il;
  } dec_t;

  dec_t q[$];
  int   exp_cnt = 0;
  bit   armed   = 1'b0;

  always @(posedge clk) begin
    dec_t d;
    bit   ir;
    if (rstn) begin
      q.delete();
      exp_cnt = 0;
      armed   = 1'b1;
    end else begin
      ir = (q.size() == 0) || bus.out_ready;
      if (q.size() != 0 && bus.out_ready) begin
`ifdef BRANCH_STATS_EN
        if (q[0].t && !q[0].il && exp_cnt < 255) exp_cnt++;
`endif
        void'(q.pop_front());
      end
      if (bus.in_valid && ir) begin
        ref_decide(bus.funct3, bus.sub, cur_a, cur_b, d.t, d.il);
        q.push_back(d);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", bus.in_ready, !rstn && (q.size() == 0 || bus.out_ready));
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("taken", bus.taken, q[0].t);
        check("illegal", bus.illegal, q[0].il);
      end
      check("taken_cnt", bus.taken_cnt, exp_cnt);
    end
  end

  int exp_sat;

  initial begin
    logic pt, pil;
`ifdef BRANCH_STATS_EN
    exp_sat = 255;
`else
    exp_sat = 0;
`endif

    // Pin the model with hand-derived expectations.
    ref_decide(3'b100, 1'b1, 8'h01, 8'h10, pt, pil); check("pin_blt_01_10", {pil, pt}, 2'b01);
    ref_decide(3'b110, 1'b1, 8'h01, 8'h10, pt, pil); check("pin_bltu_01_10", {pil, pt}, 2'b01);
    ref_decide(3'b100, 1'b1, 8'hFF, 8'h80, pt, pil); check("pin_blt_ff_80", {pil, pt}, 2'b00);
    ref_decide(3'b010, 1'b1, 8'h00, 8'h00, pt, pil); check("pin_f010", {pil, pt}, 2'b10);
    ref_decide(3'b000, 1'b0, 8'h00, 8'h00, pt, pil); check("pin_sub0", {pil, pt}, 2'b10);

    drive(1'b0, 3'b000, 1'b1, 8'h00, 8'h00, 1'b1);
    rstn = 1'b1;
    cyc(); cyc();
    check("reset_in_ready", bus.in_ready, 1'b0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_cnt", bus.taken_cnt, 0);
    rstn = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1'b1);

    // 0x01-0x10: BLT then BLTU, both taken, one cycle latency.
    drive(1'b1, F_BLT, 1'b1, 8'h01, 8'h10, 1'b1);
    check("pre_accept_valid", bus.out_valid, 1'b0);
    cyc();
    check("blt_valid", bus.out_valid, 1'b1);
    check("blt_taken", bus.taken, 1'b1);
    drive(1'b1, F_BLTU, 1'b1, 8'h01, 8'h10, 1'b1);
    cyc();
    check("bltu_taken", bus.taken, 1'b1);

    // 0xFF-0x80.
    drive(1'b1, F_BGE, 1'b1, 8'hFF, 8'h80, 1'b1);  cyc(); check("bge_taken", bus.taken, 1'b1);
    drive(1'b1, F_BGEU, 1'b1, 8'hFF, 8'h80, 1'b1); cyc(); check("bgeu_taken", bus.taken, 1'b1);
    drive(1'b1, F_BLT, 1'b1, 8'hFF, 8'h80, 1'b1);  cyc(); check("blt_nt", bus.taken, 1'b0);

    // 0x00-0x00 and illegal encodings.
    drive(1'b1, F_BEQ, 1'b1, 8'h00, 8'h00, 1'b1);  cyc(); check("beq_taken", bus.taken, 1'b1);
    drive(1'b1, F_BNE, 1'b1, 8'h00, 8'h00, 1'b1);  cyc(); check("bne_nt", bus.taken, 1'b0);
    drive(1'b1, 3'b010, 1'b1, 8'h00, 8'h00, 1'b1);
    cyc(); check("f010_ill", {bus.illegal, bus.taken}, 2'b10);
    drive(1'b1, F_BEQ, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(); check("sub0_ill", {bus.illegal, bus.taken}, 2'b10);

    // Stall for 3 cycles, then back-to-back transfers.
    drive(1'b0, F_BEQ, 1'b1, 8'h00, 8'h00, 1'b1); cyc();
    drive(1'b1, F_BEQ, 1'b1, 8'h05, 8'h05, 1'b0); cyc();
    drive(1'b1, F_BNE, 1'b1, 8'h05, 8'h05, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_hold", {bus.out_valid, bus.illegal, bus.taken}, 3'b101);
    end
    drive(1'b1, F_BNE, 1'b1, 8'h05, 8'h05, 1'b1); cyc();
    check("b2b_1", {bus.out_valid, bus.taken}, 2'b10);
    drive(1'b1, F_BEQ, 1'b1, 8'h05, 8'h05, 1'b1); cyc();
    check("b2b_2", {bus.out_valid, bus.taken}, 2'b11);

    // 300 delivered taken BEQs: counter saturates without wrapping.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, F_BEQ, 1'b1, 8'(i), 8'(i), 1'b1);
      cyc();
    end
    check("cnt_sat", bus.taken_cnt, exp_sat);

    // Reset mid-stall discards the pending decision.
    drive(1'b1, F_BEQ, 1'b1, 8'h07, 8'h07, 1'b0); cyc();
    check("pre_rst_stall", bus.out_valid, 1'b1);
    rstn = 1'b1;
    cyc();
    check("rst_stall_valid", bus.out_valid, 1'b0);
    check("rst_stall_cnt", bus.taken_cnt, 0);
    check("rst_stall_ready", bus.in_ready, 1'b0);
    rstn = 1'b0;

    // Random traffic, including illegal encodings and don't-care inputs.
    for (int i = 0; i < 800; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 7) != 0),
            a, b, 1'($urandom_range(0, 3) != 0));
      cyc();
    end

    drive(1'b0, F_BEQ, 1'b1, 8'h00, 8'h00, 1'b1);
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
